// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480 @ 60 Hz raster constants, counter widths and the
// per-pixel control bundle. The framebuffer fetch and DAC blocks use the same
// definitions.
package vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  // Vertical timing, in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;  // 800
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;  // 525

  localparam int HCOUNT_W = $clog2(VGA_H_TOTAL);
  localparam int VCOUNT_W = $clog2(VGA_V_TOTAL);

  typedef logic [HCOUNT_W-1:0] hcount_t;
  typedef logic [VCOUNT_W-1:0] vcount_t;

  // Control bits that travel with one presented pixel coordinate
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic line_start;
    logic frame_start;
  } vga_ctrl_t;

endpackage

// File: rtl/vga_sync_2ff.sv
// vga_sync_2ff: generic two-flop synchronizer with async active-low reset.
// Brings a slow level signal (e.g. a PLL lock flag) into the clk domain.
module vga_sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage shift: the first stage may go metastable, the second resolves it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      // NOTE: non-blocking so q takes the old meta value, giving two real stages.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: 640x480 @ 60 Hz raster generator in the pixel clock domain.
// The synchronized PLL lock acts as a run enable; while it is low everything
// idles at reset values and the next run starts at (0,0) with frame_start.
// Optional feature macro: VGA_TIMING_FETCH_EN adds fetch_x/fetch_y/fetch_valid,
// a coordinate FETCH_LEAD clocks ahead of pixel_x/pixel_y for framebuffer reads.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = VGA_H_ACTIVE,
  parameter int   H_FP       = VGA_H_FP,
  parameter int   H_SYNC     = VGA_H_SYNC,
  parameter int   H_BP       = VGA_H_BP,
  parameter int   V_ACTIVE   = VGA_V_ACTIVE,
  parameter int   V_FP       = VGA_V_FP,
  parameter int   V_SYNC     = VGA_V_SYNC,
  parameter int   V_BP       = VGA_V_BP,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   FETCH_LEAD = 2,
  localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW         = $clog2(H_TOTAL),
  localparam int  VW         = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          pll_locked,
`ifdef VGA_TIMING_FETCH_EN
  output logic [HW-1:0] fetch_x,
  output logic [VW-1:0] fetch_y,
  output logic          fetch_valid,
`endif
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [HW-1:0] pixel_x,
  output logic [VW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  // The fetch counter is preset to FETCH_LEAD on line 0, so the lead must be
  // shorter than one line.
  if (FETCH_LEAD < 0 || FETCH_LEAD >= H_TOTAL) begin : g_bad_lead
    $error("vga_timing: FETCH_LEAD must lie in [0, H_TOTAL-1]");
  end

  // Counter decode points, sized to the counters so compares are unsigned
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam vga_ctrl_t CTRL_IDLE = '{
    hsync:       ~HSYNC_POL,
    vsync:       ~VSYNC_POL,
    active:      1'b0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  function automatic logic [HW-1:0] h_step(input logic [HW-1:0] h);
    return (h == H_LAST) ? '0 : h + 1'b1;
  endfunction

  // v advances only when h wraps, so vsync is line-aligned by construction
  function automatic logic [VW-1:0] v_step(input logic [HW-1:0] h, input logic [VW-1:0] v);
    if (h != H_LAST) return v;
    return (v == V_LAST) ? '0 : v + 1'b1;
  endfunction

  function automatic logic is_active(input logic [HW-1:0] h, input logic [VW-1:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction

  function automatic vga_ctrl_t decode(input logic [HW-1:0] h, input logic [VW-1:0] v);
    vga_ctrl_t c;
    c.active      = is_active(h, v);
    c.hsync       = (h >= HS_BEG && h <= HS_END) ? HSYNC_POL : ~HSYNC_POL;
    c.vsync       = (v >= VS_BEG && v <= VS_END) ? VSYNC_POL : ~VSYNC_POL;
    c.line_start  = (h == '0);
    c.frame_start = (h == '0) && (v == '0);
    return c;
  endfunction

  logic run;

  vga_sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b0)
  ) u_lock_sync (
    .clk  (clock),
    .rst_n(reset_n),
    .d    (pll_locked),
    .q    (run)
  );

  // h_cnt/v_cnt hold the coordinate to present on the next clock; the output
  // registers below take it together with its decoded control bits.
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [HW-1:0] pixel_x_q;
  logic [VW-1:0] pixel_y_q;
  vga_ctrl_t     ctrl_q;

  // Raster counters and aligned output registers; idle at (0,0) while not running
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      pixel_x_q <= '0;
      pixel_y_q <= '0;
      ctrl_q    <= CTRL_IDLE;
    end else if (!run) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      pixel_x_q <= '0;
      pixel_y_q <= '0;
      ctrl_q    <= CTRL_IDLE;
    end else begin
      h_cnt     <= h_step(h_cnt);
      v_cnt     <= v_step(h_cnt, v_cnt);
      pixel_x_q <= h_cnt;
      pixel_y_q <= v_cnt;
      ctrl_q    <= decode(h_cnt, v_cnt);
    end
  end

  // Masking with run blanks the outputs on the same edge run falls, instead of
  // one clock later when the registers clear; both inputs are flops, so the
  // result stays glitch-free. On the rising side the registers still hold idle
  // values, so the first visible coordinate is (0,0) one clock after run rises.
  vga_ctrl_t ctrl_o;
  assign ctrl_o      = run ? ctrl_q : CTRL_IDLE;
  assign pixel_x     = run ? pixel_x_q : '0;
  assign pixel_y     = run ? pixel_y_q : '0;
  assign hsync       = ctrl_o.hsync;
  assign vsync       = ctrl_o.vsync;
  assign active      = ctrl_o.active;
  assign line_start  = ctrl_o.line_start;
  assign frame_start = ctrl_o.frame_start;

`ifdef VGA_TIMING_FETCH_EN
  // Lead counter: same sequence as h_cnt/v_cnt, started FETCH_LEAD pixels ahead
  localparam logic [HW-1:0] FH_PRESET = HW'(FETCH_LEAD);

  logic [HW-1:0] fh_cnt;
  logic [VW-1:0] fv_cnt;
  logic [HW-1:0] fetch_x_q;
  logic [VW-1:0] fetch_y_q;
  logic          fetch_valid_q;

  // Lead counter and its registered outputs, aligned with pixel_x/pixel_y
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fh_cnt        <= FH_PRESET;
      fv_cnt        <= '0;
      fetch_x_q     <= '0;
      fetch_y_q     <= '0;
      fetch_valid_q <= 1'b0;
    end else if (!run) begin
      fh_cnt        <= FH_PRESET;
      fv_cnt        <= '0;
      fetch_x_q     <= '0;
      fetch_y_q     <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      fh_cnt        <= h_step(fh_cnt);
      fv_cnt        <= v_step(fh_cnt, fv_cnt);
      fetch_x_q     <= fh_cnt;
      fetch_y_q     <= fv_cnt;
      fetch_valid_q <= is_active(fh_cnt, fv_cnt);
    end
  end

  assign fetch_x     = run ? fetch_x_q : '0;
  assign fetch_y     = run ? fetch_y_q : '0;
  assign fetch_valid = run & fetch_valid_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed self-checking bench for vga_timing.
// u_dut uses the real 640x480 timing for line-level checks; u_small uses a
// tiny raster (15 x 9, active-high hsync) so whole frames, frame wraps and the
// lead counter are exercised in a few hundred clocks.
module tb_vga_timing;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  logic lock_a;
  logic lock_b;

  // Full-size instance
  logic       hsync_a, vsync_a, active_a, ls_a, fs_a;
  logic [9:0] x_a;
  logic [9:0] y_a;
  // Small instance
  logic       hsync_b, vsync_b, active_b, ls_b, fs_b;
  logic [3:0] x_b;
  logic [3:0] y_b;
`ifdef VGA_TIMING_FETCH_EN
  logic [9:0] fx_a, fy_a;
  logic       fv_a;
  logic [3:0] fx_b, fy_b;
  logic       fv_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  vga_timing u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pll_locked (lock_a),
`ifdef VGA_TIMING_FETCH_EN
    .fetch_x    (fx_a),
    .fetch_y    (fy_a),
    .fetch_valid(fv_a),
`endif
    .hsync      (hsync_a),
    .vsync      (vsync_a),
    .active     (active_a),
    .pixel_x    (x_a),
    .pixel_y    (y_a),
    .line_start (ls_a),
    .frame_start(fs_a)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .FETCH_LEAD(2)
  ) u_small (
    .clock      (clock),
    .reset_n    (reset_n),
    .pll_locked (lock_b),
`ifdef VGA_TIMING_FETCH_EN
    .fetch_x    (fx_b),
    .fetch_y    (fy_b),
    .fetch_valid(fv_b),
`endif
    .hsync      (hsync_b),
    .vsync      (vsync_b),
    .active     (active_b),
    .pixel_x    (x_b),
    .pixel_y    (y_b),
    .line_start (ls_b),
    .frame_start(fs_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance one clock and sample away from the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes;
    int ex, ey, ef, efx, efy;
    int err_xy, err_act, err_hs, err_vs, err_ls, err_fs, err_fetch;
    int act_cnt, hs_cnt, hs_first, ls_cnt, ls_second;
    int vs_cnt, vs_first_y, fs_cnt, fs_second;
    int fv_798, fx_134, fy_134;
    logic e_hs, e_vs, e_act, e_fv;

    reset_n = 1'b0;
    lock_a  = 1'b0;
    lock_b  = 1'b0;
    #23;
    reset_n = 1'b1;

    // ---- Idle with lock low: everything at reset values, no strobes ----
    strobes = 0;
    repeat (100) begin
      tick();
      if (ls_a || fs_a || ls_b || fs_b) strobes++;
    end
    check("idle_x", int'(x_a), 0);
    check("idle_y", int'(y_a), 0);
    check("idle_hsync", int'(hsync_a), 1);
    check("idle_vsync", int'(vsync_a), 1);
    check("idle_active", int'(active_a), 0);
    check("idle_strobes", strobes, 0);
    check("idle_hsync_pos_pol", int'(hsync_b), 0);
    check("idle_vsync_small", int'(vsync_b), 1);
`ifdef VGA_TIMING_FETCH_EN
    check("idle_fetch_x", int'(fx_a), 0);
    check("idle_fetch_valid", int'(fv_a), 0);
`endif

    // ---- Lock rises: frame_start exactly 3 clocks later at (0,0) ----
    @(negedge clock);
    lock_a = 1'b1;
    tick();
    check("lock_lat1_fs", int'(fs_a), 0);
    tick();
    check("lock_lat2_fs", int'(fs_a), 0);
    check("lock_lat2_active", int'(active_a), 0);
    tick();
    check("lock_lat3_fs", int'(fs_a), 1);
    check("lock_lat3_active", int'(active_a), 1);
    check("lock_lat3_x", int'(x_a), 0);
    check("lock_lat3_y", int'(y_a), 0);

    // ---- Two full lines at 640x480 timing ----
    err_xy = 0; err_act = 0; err_hs = 0; err_vs = 0; err_ls = 0; err_fs = 0; err_fetch = 0;
    act_cnt = 0; hs_cnt = 0; hs_first = -1; ls_cnt = 0; ls_second = -1; fv_798 = -1;
    for (int c = 0; c < 1600; c++) begin
      ex    = c % 800;
      ey    = c / 800;
      e_act = (ex < 640) && (ey < 480);
      e_hs  = !(ex >= 656 && ex <= 751);
      if (int'(x_a) != ex || int'(y_a) != ey) err_xy++;
      if (active_a !== e_act) err_act++;
      if (hsync_a !== e_hs) err_hs++;
      if (vsync_a !== 1'b1) err_vs++;
      if (ls_a !== (ex == 0)) err_ls++;
      if (fs_a !== (c == 0)) err_fs++;
      if (ey == 0) begin
        if (active_a) act_cnt++;
        if (!hsync_a) begin
          if (hs_cnt == 0) hs_first = int'(x_a);
          hs_cnt++;
        end
      end
      if (ls_a) begin
        ls_cnt++;
        if (c > 0 && ls_second < 0) ls_second = c;
      end
`ifdef VGA_TIMING_FETCH_EN
      ef   = c + 2;
      efx  = ef % 800;
      efy  = ef / 800;
      e_fv = (efx < 640) && (efy < 480);
      if (int'(fx_a) != efx || int'(fy_a) != efy || fv_a !== e_fv) err_fetch++;
      if (c == 798) fv_798 = int'(fv_a);
`endif
      tick();
    end
    check("line_xy_track", err_xy, 0);
    check("line_active_track", err_act, 0);
    check("line_hsync_track", err_hs, 0);
    check("line_vsync_idle", err_vs, 0);
    check("line_start_track", err_ls, 0);
    check("line_frame_start_track", err_fs, 0);
    check("line_active_count", act_cnt, 640);
    check("line_hsync_low_count", hs_cnt, 96);
    check("line_hsync_first_x", hs_first, 656);
    check("line_start_count", ls_cnt, 2);
    check("line_start_period", ls_second, 800);
`ifdef VGA_TIMING_FETCH_EN
    check("line_fetch_track", err_fetch, 0);
    check("fetch_valid_lead", fv_798, 1);
`endif

    // ---- Drop lock mid-line at (300,2), then re-raise ----
    repeat (300) tick();
    check("drop_pre_x", int'(x_a), 300);
    check("drop_pre_y", int'(y_a), 2);
    check("drop_pre_active", int'(active_a), 1);
    @(negedge clock);
    lock_a = 1'b0;
    tick();
    tick();
    check("drop_x", int'(x_a), 0);
    check("drop_y", int'(y_a), 0);
    check("drop_active", int'(active_a), 0);
    check("drop_hsync", int'(hsync_a), 1);
    check("drop_line_start", int'(ls_a), 0);
    repeat (5) tick();
    check("drop_hold_active", int'(active_a), 0);
    check("drop_hold_x", int'(x_a), 0);
    @(negedge clock);
    lock_a = 1'b1;
    tick();
    tick();
    check("relock_lat2_fs", int'(fs_a), 0);
    tick();
    check("relock_fs", int'(fs_a), 1);
    check("relock_x", int'(x_a), 0);
    check("relock_y", int'(y_a), 0);

    // ---- Small raster: two whole frames, frame wrap, vsync, lead counter ----
    @(negedge clock);
    lock_b = 1'b1;
    repeat (3) tick();
    err_xy = 0; err_act = 0; err_hs = 0; err_vs = 0; err_ls = 0; err_fs = 0; err_fetch = 0;
    vs_cnt = 0; vs_first_y = -1; fs_cnt = 0; fs_second = -1; fx_134 = -1; fy_134 = -1;
    for (int c = 0; c < 270; c++) begin
      ex    = c % 15;
      ey    = (c / 15) % 9;
      e_act = (ex < 8) && (ey < 4);
      e_hs  = (ex >= 10 && ex <= 12);
      e_vs  = !(ey == 5 || ey == 6);
      if (int'(x_b) != ex || int'(y_b) != ey) err_xy++;
      if (active_b !== e_act) err_act++;
      if (hsync_b !== e_hs) err_hs++;
      if (vsync_b !== e_vs) err_vs++;
      if (ls_b !== (ex == 0)) err_ls++;
      if (fs_b !== (c % 135 == 0)) err_fs++;
      if (c < 135 && !vsync_b) begin
        if (vs_cnt == 0) vs_first_y = int'(y_b);
        vs_cnt++;
      end
      if (fs_b) begin
        fs_cnt++;
        if (c > 0 && fs_second < 0) fs_second = c;
      end
`ifdef VGA_TIMING_FETCH_EN
      ef   = c + 2;
      efx  = ef % 15;
      efy  = (ef / 15) % 9;
      e_fv = (efx < 8) && (efy < 4);
      if (int'(fx_b) != efx || int'(fy_b) != efy || fv_b !== e_fv) err_fetch++;
      if (c == 134) begin
        fx_134 = int'(fx_b);
        fy_134 = int'(fy_b);
      end
`endif
      tick();
    end
    check("small_xy_track", err_xy, 0);
    check("small_active_track", err_act, 0);
    check("small_hsync_track", err_hs, 0);
    check("small_vsync_track", err_vs, 0);
    check("small_line_start_track", err_ls, 0);
    check("small_frame_start_track", err_fs, 0);
    check("small_vsync_low_count", vs_cnt, 30);
    check("small_vsync_first_line", vs_first_y, 5);
    check("small_frame_start_count", fs_cnt, 2);
    check("small_frame_period", fs_second, 135);
`ifdef VGA_TIMING_FETCH_EN
    check("small_fetch_track", err_fetch, 0);
    check("small_fetch_wrap_x", fx_134, 1);
    check("small_fetch_wrap_y", fy_134, 0);
`endif

    // ---- Async reset mid-frame, then lock re-qualification ----
    repeat (3) tick();
    check("pre_rst_x_small", int'(x_b), 3);
    check("pre_rst_x_big", int'(x_a), 276);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_x_big", int'(x_a), 0);
    check("rst_async_active_big", int'(active_a), 0);
    check("rst_async_x_small", int'(x_b), 0);
    check("rst_async_hsync_small", int'(hsync_b), 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("rst_idle1_active", int'(active_a), 0);
    check("rst_idle1_fs", int'(fs_a), 0);
    tick();
    check("rst_idle2_fs", int'(fs_a), 0);
    check("rst_idle2_fs_small", int'(fs_b), 0);
    tick();
    check("rst_restart_fs", int'(fs_a), 1);
    check("rst_restart_fs_small", int'(fs_b), 1);
    check("rst_restart_x", int'(x_a), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
